// File: rtl/nw_traceback.sv
// Needleman-Wunsch traceback: walks the direction matrix from (N,N) to (0,0), one step pulse per move.
// Interior move 3 cycles (read, wait, decode), boundary move 1 cycle; en_traceB low aborts, ending holds until it falls.
module nw_traceback #(
    parameter int N      = 8,
    parameter int IDX_W  = 4,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_traceB,
    output logic              dir_rd_en,
    output logic [ADDR_W-1:0] dir_addr,
    input  logic [1:0]        dir_data,
    output logic              step_valid,
    output logic [1:0]        step_op,
    output logic [IDX_W-1:0]  step_i,
    output logic [IDX_W-1:0]  step_j,
    output logic              ending,
    output logic              err
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CHECK  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_DECODE = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [1:0] OP_DIAG = 2'b00;
    localparam logic [1:0] OP_UP   = 2'b01;
    localparam logic [1:0] OP_LEFT = 2'b10;

    localparam logic [IDX_W-1:0]  IDX_N   = IDX_W'(N);
    localparam logic [IDX_W-1:0]  IDX_ONE = IDX_W'(1);
    localparam logic [ADDR_W-1:0] ROW_LEN = ADDR_W'(N + 1);

    logic [2:0]        state_q, state_d;
    logic [IDX_W-1:0]  i_q, i_d, j_q, j_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              step_vld_q, step_vld_d;
    logic [1:0]        step_op_q, step_op_d;
    logic [IDX_W-1:0]  step_i_q, step_i_d, step_j_q, step_j_d;
    logic              ending_q, ending_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr_calc;

    assign addr_calc = ADDR_W'(i_q) * ROW_LEN + ADDR_W'(j_q);

    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        j_d        = j_q;
        rd_en_d    = 1'b0;
        addr_d     = addr_q;
        step_vld_d = 1'b0;
        step_op_d  = step_op_q;
        step_i_d   = step_i_q;
        step_j_d   = step_j_q;
        ending_d   = ending_q;
        err_d      = err_q;
        case (state_q)
            S_IDLE: begin
                if (en_traceB) begin
                    i_d     = IDX_N;
                    j_d     = IDX_N;
                    err_d   = 1'b0;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (!en_traceB) begin
                    state_d = S_IDLE;
                end else if (i_q == '0 && j_q == '0) begin
                    ending_d = 1'b1;
                    state_d  = S_DONE;
                end else if (i_q == '0) begin
                    // First row: only LEFT is possible, no memory access needed
                    step_vld_d = 1'b1;
                    step_op_d  = OP_LEFT;
                    step_i_d   = i_q;
                    step_j_d   = j_q;
                    j_d        = j_q - IDX_ONE;
                end else if (j_q == '0) begin
                    step_vld_d = 1'b1;
                    step_op_d  = OP_UP;
                    step_i_d   = i_q;
                    step_j_d   = j_q;
                    i_d        = i_q - IDX_ONE;
                end else begin
                    rd_en_d = 1'b1;
                    addr_d  = addr_calc;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                state_d = en_traceB ? S_DECODE : S_IDLE;
            end
            S_DECODE: begin
                if (!en_traceB) begin
                    state_d = S_IDLE;
                end else if (dir_data == 2'b11) begin
                    err_d    = 1'b1;
                    ending_d = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    step_vld_d = 1'b1;
                    step_op_d  = dir_data;
                    step_i_d   = i_q;
                    step_j_d   = j_q;
                    if (dir_data != OP_LEFT) i_d = i_q - IDX_ONE;
                    if (dir_data != OP_UP)   j_d = j_q - IDX_ONE;
                    state_d    = S_CHECK;
                end
            end
            S_DONE: begin
                if (!en_traceB) begin
                    ending_d = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            i_q        <= '0;
            j_q        <= '0;
            rd_en_q    <= 1'b0;
            addr_q     <= '0;
            step_vld_q <= 1'b0;
            step_op_q  <= '0;
            step_i_q   <= '0;
            step_j_q   <= '0;
            ending_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            j_q        <= j_d;
            rd_en_q    <= rd_en_d;
            addr_q     <= addr_d;
            step_vld_q <= step_vld_d;
            step_op_q  <= step_op_d;
            step_i_q   <= step_i_d;
            step_j_q   <= step_j_d;
            ending_q   <= ending_d;
            err_q      <= err_d;
        end
    end

    assign dir_rd_en  = rd_en_q;
    assign dir_addr   = addr_q;
    assign step_valid = step_vld_q;
    assign step_op    = step_op_q;
    assign step_i     = step_i_q;
    assign step_j     = step_j_q;
    assign ending     = ending_q;
    assign err        = err_q;

endmodule

// File: tb/tb_nw_traceback.sv
// Directed bench for nw_traceback: one N=4 instance and one N=2 instance, each with a registered-read direction memory.
module tb_nw_traceback;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en_a = 1'b0, en_b = 1'b0;
    logic       rd_a, rd_b;
    logic [6:0] addr_a;
    logic [3:0] addr_b;
    logic [1:0] dd_a = 2'b00, dd_b = 2'b00;
    logic       sv_a, sv_b;
    logic [1:0] op_a, op_b;
    logic [3:0] si_a, sj_a;
    logic [1:0] si_b, sj_b;
    logic       end_a, end_b, err_a, err_b;

    logic [1:0] mem_a [0:127];
    logic [1:0] mem_b [0:15];

    int n_checks = 0;
    int n_fail   = 0;

    int st_k[$], st_op[$], st_i[$], st_j[$], rd_addr[$];
    int end_k;
    int rd_consec;
    logic end_err;

    always #5 clk = ~clk;

    nw_traceback #(.N(4), .IDX_W(4), .ADDR_W(7)) u_dut_a (
        .clk(clk), .rst(rst), .en_traceB(en_a), .dir_rd_en(rd_a), .dir_addr(addr_a),
        .dir_data(dd_a), .step_valid(sv_a), .step_op(op_a), .step_i(si_a), .step_j(sj_a),
        .ending(end_a), .err(err_a)
    );

    nw_traceback #(.N(2), .IDX_W(2), .ADDR_W(4)) u_dut_b (
        .clk(clk), .rst(rst), .en_traceB(en_b), .dir_rd_en(rd_b), .dir_addr(addr_b),
        .dir_data(dd_b), .step_valid(sv_b), .step_op(op_b), .step_i(si_b), .step_j(sj_b),
        .ending(end_b), .err(err_b)
    );

    always @(posedge clk) begin
        if (rd_a) dd_a <= mem_a[addr_a];
        if (rd_b) dd_b <= mem_b[addr_b];
    end

    task automatic fill_a(input logic [1:0] c);
        for (int n = 0; n < 128; n++) mem_a[n] = c;
    endtask

    task automatic fill_b(input logic [1:0] c);
        for (int n = 0; n < 16; n++) mem_b[n] = c;
    endtask

    // Raises the enable, then records every step, read and the ending edge (counted from the start edge).
    task automatic capture(input int sel, input int maxc);
        logic prev_rd, v, rd, e, er;
        int op, si, sj, ad;
        prev_rd = 1'b0;
        st_k.delete(); st_op.delete(); st_i.delete(); st_j.delete(); rd_addr.delete();
        end_k = -1; end_err = 1'b0; rd_consec = 0;
        if (sel == 0) en_a = 1'b1; else en_b = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= maxc; k++) begin
            @(posedge clk); #1;
            if (sel == 0) begin
                v = sv_a; op = int'(op_a); si = int'(si_a); sj = int'(sj_a);
                rd = rd_a; ad = int'(addr_a); e = end_a; er = err_a;
            end else begin
                v = sv_b; op = int'(op_b); si = int'(si_b); sj = int'(sj_b);
                rd = rd_b; ad = int'(addr_b); e = end_b; er = err_b;
            end
            if (v) begin
                st_k.push_back(k); st_op.push_back(op); st_i.push_back(si); st_j.push_back(sj);
            end
            if (rd) begin
                rd_addr.push_back(ad);
                if (prev_rd) rd_consec++;
            end
            prev_rd = rd;
            if (e) begin
                end_k = k; end_err = er;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if ({rd_a, addr_a, sv_a, op_a, si_a, sj_a, end_a, err_a} !== 18'd0) begin
            n_fail++; $display("FAIL reset_a: got %h expected 0", {rd_a, addr_a, sv_a, op_a, si_a, sj_a, end_a, err_a});
        end
        n_checks++;
        if ({rd_b, addr_b, sv_b, op_b, si_b, sj_b, end_b, err_b} !== 13'd0) begin
            n_fail++; $display("FAIL reset_b: got %h expected 0", {rd_b, addr_b, sv_b, op_b, si_b, sj_b, end_b, err_b});
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_all_diag();
        int exp_ij[4] = '{4, 3, 2, 1};
        int exp_ad[4] = '{24, 18, 12, 6};
        fill_a(2'b00);
        capture(0, 40);
        n_checks++;
        if (st_k.size() !== 4) begin n_fail++; $display("FAIL diag_nsteps: got %0d expected 4", st_k.size()); end
        for (int s = 0; s < 4 && s < st_k.size(); s++) begin
            n_checks++;
            if (st_k[s] !== 3 * (s + 1) || st_op[s] !== 0 || st_i[s] !== exp_ij[s] || st_j[s] !== exp_ij[s]) begin
                n_fail++;
                $display("FAIL diag_step%0d: got k=%0d op=%0d (%0d,%0d) expected k=%0d op=0 (%0d,%0d)",
                         s, st_k[s], st_op[s], st_i[s], st_j[s], 3 * (s + 1), exp_ij[s], exp_ij[s]);
            end
        end
        n_checks++;
        if (end_k !== 13 || end_err !== 1'b0) begin
            n_fail++; $display("FAIL diag_ending: got edge %0d err %0b expected edge 13 err 0", end_k, end_err);
        end
        n_checks++;
        if (rd_addr.size() !== 4 || rd_consec !== 0) begin
            n_fail++; $display("FAIL diag_reads: got %0d reads %0d back-to-back expected 4 reads 0", rd_addr.size(), rd_consec);
        end
        for (int s = 0; s < 4 && s < rd_addr.size(); s++) begin
            n_checks++;
            if (rd_addr[s] !== exp_ad[s]) begin
                n_fail++; $display("FAIL diag_addr%0d: got %0d expected %0d", s, rd_addr[s], exp_ad[s]);
            end
        end
        @(posedge clk); #1;
        n_checks++;
        if (end_a !== 1'b1) begin n_fail++; $display("FAIL diag_ending_hold: got %0b expected 1", end_a); end
        en_a = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (end_a !== 1'b0) begin n_fail++; $display("FAIL diag_ending_drop: got %0b expected 0", end_a); end
        @(posedge clk); #1;
    endtask

    task automatic test_all_up();
        int exp_k[8]  = '{3, 6, 9, 12, 13, 14, 15, 16};
        int exp_op[8] = '{1, 1, 1, 1, 2, 2, 2, 2};
        int exp_i[8]  = '{4, 3, 2, 1, 0, 0, 0, 0};
        int exp_j[8]  = '{4, 4, 4, 4, 4, 3, 2, 1};
        int exp_ad[4] = '{24, 19, 14, 9};
        fill_a(2'b01);
        capture(0, 40);
        n_checks++;
        if (st_k.size() !== 8) begin n_fail++; $display("FAIL up_nsteps: got %0d expected 8", st_k.size()); end
        for (int s = 0; s < 8 && s < st_k.size(); s++) begin
            n_checks++;
            if (st_k[s] !== exp_k[s] || st_op[s] !== exp_op[s] || st_i[s] !== exp_i[s] || st_j[s] !== exp_j[s]) begin
                n_fail++;
                $display("FAIL up_step%0d: got k=%0d op=%0d (%0d,%0d) expected k=%0d op=%0d (%0d,%0d)",
                         s, st_k[s], st_op[s], st_i[s], st_j[s], exp_k[s], exp_op[s], exp_i[s], exp_j[s]);
            end
        end
        n_checks++;
        if (end_k !== 17) begin n_fail++; $display("FAIL up_ending: got edge %0d expected 17", end_k); end
        n_checks++;
        if (rd_addr.size() !== 4) begin n_fail++; $display("FAIL up_nreads: got %0d expected 4", rd_addr.size()); end
        for (int s = 0; s < 4 && s < rd_addr.size(); s++) begin
            n_checks++;
            if (rd_addr[s] !== exp_ad[s]) begin
                n_fail++; $display("FAIL up_addr%0d: got %0d expected %0d", s, rd_addr[s], exp_ad[s]);
            end
        end
        en_a = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_invalid();
        logic seen;
        seen = 1'b0;
        fill_a(2'b11);
        en_a = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            if (sv_a) seen = 1'b1;
            if (k == 2) begin
                n_checks++;
                if (end_a !== 1'b0) begin n_fail++; $display("FAIL inv_early_ending: got %0b expected 0", end_a); end
            end
        end
        n_checks++;
        if (end_a !== 1'b1 || err_a !== 1'b1) begin
            n_fail++; $display("FAIL inv_flags: got ending %0b err %0b expected 1 1", end_a, err_a);
        end
        n_checks++;
        if (seen !== 1'b0) begin n_fail++; $display("FAIL inv_nostep: got step_valid %0b expected 0", seen); end
        en_a = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (end_a !== 1'b0 || err_a !== 1'b1) begin
            n_fail++; $display("FAIL inv_drop: got ending %0b err %0b expected 0 1", end_a, err_a);
        end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (err_a !== 1'b1) begin n_fail++; $display("FAIL inv_err_sticky: got %0b expected 1", err_a); end
        fill_a(2'b00);
        en_a = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (err_a !== 1'b0) begin n_fail++; $display("FAIL inv_err_clear: got %0b expected 0", err_a); end
        en_a = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_abort();
        int nsteps;
        logic bad;
        nsteps = 0; bad = 1'b0;
        fill_a(2'b00);
        en_a = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            if (sv_a) nsteps++;
        end
        n_checks++;
        if (nsteps !== 2) begin n_fail++; $display("FAIL abort_pre_steps: got %0d expected 2", nsteps); end
        en_a = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (sv_a || end_a || rd_a) bad = 1'b1;
        end
        n_checks++;
        if (bad !== 1'b0) begin n_fail++; $display("FAIL abort_quiet: got activity %0b expected 0", bad); end
        capture(0, 40);
        n_checks++;
        if (st_k.size() !== 4 || end_k !== 13 || end_err !== 1'b0) begin
            n_fail++; $display("FAIL abort_restart: got %0d steps ending edge %0d err %0b expected 4 13 0", st_k.size(), end_k, end_err);
        end
        n_checks++;
        if (st_k.size() < 1 || st_i[0] !== 4 || st_j[0] !== 4 || st_k[0] !== 3) begin
            n_fail++; $display("FAIL abort_restart_first: got %0d steps expected first step (4,4) at edge 3", st_k.size());
        end
        en_a = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_wait();
        fill_a(2'b00);
        en_a = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++;
        if (rd_a !== 1'b1 || addr_a !== 7'd24) begin
            n_fail++; $display("FAIL rstw_in_wait: got rd %0b addr %0d expected 1 24", rd_a, addr_a);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({rd_a, addr_a, sv_a, op_a, si_a, sj_a, end_a, err_a} !== 18'd0) begin
            n_fail++; $display("FAIL rstw_outputs: got %h expected 0", {rd_a, addr_a, sv_a, op_a, si_a, sj_a, end_a, err_a});
        end
        en_a = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        capture(0, 40);
        n_checks++;
        if (st_k.size() !== 4 || end_k !== 13) begin
            n_fail++; $display("FAIL rstw_restart: got %0d steps ending edge %0d expected 4 13", st_k.size(), end_k);
        end
        n_checks++;
        if (st_k.size() < 1 || st_i[0] !== 4 || st_j[0] !== 4) begin
            n_fail++; $display("FAIL rstw_first_step: got %0d steps expected first from (4,4)", st_k.size());
        end
        en_a = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_mixed_n2();
        int exp_k[3]  = '{3, 6, 7};
        int exp_op[3] = '{2, 0, 1};
        int exp_i[3]  = '{2, 2, 1};
        int exp_j[3]  = '{2, 1, 0};
        fill_b(2'b11);
        mem_b[8] = 2'b10;
        mem_b[7] = 2'b00;
        capture(1, 40);
        n_checks++;
        if (st_k.size() !== 3) begin n_fail++; $display("FAIL mix_nsteps: got %0d expected 3", st_k.size()); end
        for (int s = 0; s < 3 && s < st_k.size(); s++) begin
            n_checks++;
            if (st_k[s] !== exp_k[s] || st_op[s] !== exp_op[s] || st_i[s] !== exp_i[s] || st_j[s] !== exp_j[s]) begin
                n_fail++;
                $display("FAIL mix_step%0d: got k=%0d op=%0d (%0d,%0d) expected k=%0d op=%0d (%0d,%0d)",
                         s, st_k[s], st_op[s], st_i[s], st_j[s], exp_k[s], exp_op[s], exp_i[s], exp_j[s]);
            end
        end
        n_checks++;
        if (end_k !== 8 || end_err !== 1'b0) begin
            n_fail++; $display("FAIL mix_ending: got edge %0d err %0b expected 8 0", end_k, end_err);
        end
        n_checks++;
        if (rd_addr.size() !== 2 || (rd_addr.size() == 2 && (rd_addr[0] !== 8 || rd_addr[1] !== 7))) begin
            n_fail++; $display("FAIL mix_addr: got %0d reads expected addresses 8 then 7", rd_addr.size());
        end
        en_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        fill_a(2'b00);
        fill_b(2'b00);
        test_reset();
        test_all_diag();
        test_all_up();
        test_invalid();
        test_abort();
        test_reset_wait();
        test_mixed_n2();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
